// File: rtl/mux_scan_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module : mux_scan_pkg                                              |
// | Brief  : Shared types and constants for the 8:1 mux scan sequencer |
// | Rev    : 1.0 - initial release                                     |
// +--------------------------------------------------------------------+
package mux_scan_pkg;

  localparam int SEL_W = 3;
  localparam int N_CH  = 8;
  localparam logic [SEL_W-1:0] LAST_CH = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage : mux_scan_pkg
`default_nettype wire

// File: rtl/mux_scan_ctrl_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module : mux_scan_ctrl_if                                          |
// | Brief  : Consumer/mux-side bundle of the scan sequencer            |
// | Rev    : 1.0 - initial release                                     |
// +--------------------------------------------------------------------+
interface mux_scan_ctrl_if;
  import mux_scan_pkg::*;

  logic                    start;
  logic                    cont;
  logic                    mux_out;
  logic [SEL_W-1:0]        sel;
  logic                    busy;
  logic                    done;
  logic [N_CH-1:0]         data;

  modport master (
    output start, cont, mux_out,
    input  sel, busy, done, data
  );

  modport slave (
    input  start, cont, mux_out,
    output sel, busy, done, data
  );

endinterface : mux_scan_ctrl_if
`default_nettype wire

// File: rtl/mux_scan_ctrl_settle_timer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module : settle_timer                                              |
// | Brief  : Hold counter; term flags that the select has settled      |
// | Rev    : 1.0 - initial release                                     |
// +--------------------------------------------------------------------+
module settle_timer #(
  parameter int unsigned SETTLE = 0
) (
  input  wire logic clk,
  input  wire logic rst,
  input  wire logic clr,
  input  wire logic inc,
  output logic      term
);

  logic [3:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= 4'd0;
    end else if (clr) begin
      r_cnt <= 4'd0;
    end else if (inc) begin
      r_cnt <= r_cnt + 4'd1;
    end
  end

  assign term = (r_cnt == 4'(SETTLE));

endmodule : settle_timer
`default_nettype wire

// File: rtl/mux_scan_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module : mux_scan_ctrl                                             |
// | Brief  : Steps an 8:1 mux select and assembles an 8-bit snapshot   |
// | Rev    : 1.0 - initial release                                     |
// +--------------------------------------------------------------------+
module mux_scan_ctrl
  import mux_scan_pkg::*;
#(
  parameter int unsigned SETTLE = 0
) (
  input  wire logic     clk,
  input  wire logic     rst,
  mux_scan_ctrl_if.slave bus
);

  state_t            r_state, w_next_state;
  logic [SEL_W-1:0]  r_sel;
  logic [N_CH-1:0]   r_shadow;
  logic [N_CH-1:0]   w_shadow_next;
  logic [N_CH-1:0]   r_data;
  logic              w_term;
  logic              w_sample;
  logic              w_capture;
  logic              w_sel_clr;
  logic              w_scanning;

  assign w_scanning = (r_state == ST_SCAN);

  settle_timer #(.SETTLE(SETTLE)) u_settle_timer (
    .clk  (clk),
    .rst  (rst),
    .clr  (!w_scanning || w_term),
    .inc  (w_scanning),
    .term (w_term)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_sample     = 1'b0;
    w_capture    = 1'b0;
    w_sel_clr    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_sel_clr = 1'b1;
        if (bus.start) w_next_state = ST_SCAN;
      end
      ST_SCAN: begin
        if (w_term) begin
          w_sample = 1'b1;
          if (r_sel == LAST_CH) begin
            w_capture    = 1'b1;
            w_next_state = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        w_sel_clr    = 1'b1;
        w_next_state = bus.cont ? ST_SCAN : ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // The final channel is merged in on the same edge it is sampled, so data
  // is published from the updated shadow rather than the registered one.
  always_comb begin
    w_shadow_next        = r_shadow;
    w_shadow_next[r_sel] = bus.mux_out;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sel    <= '0;
      r_shadow <= '0;
      r_data   <= '0;
    end else begin
      if (w_sel_clr) begin
        r_sel <= '0;
      end else if (w_sample && (r_sel != LAST_CH)) begin
        r_sel <= r_sel + 3'd1;
      end
      if (w_sample)  r_shadow <= w_shadow_next;
      if (w_capture) r_data   <= w_shadow_next;
    end
  end

  assign bus.sel  = r_sel;
  assign bus.busy = (r_state != ST_IDLE);
  assign bus.done = (r_state == ST_DONE);
  assign bus.data = r_data;

endmodule : mux_scan_ctrl
`default_nettype wire

// File: tb/tb_mux_scan_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module : tb_mux_scan_ctrl                                          |
// | Brief  : Directed bench for mux_scan_ctrl with SETTLE=0 and 2      |
// | Rev    : 1.0 - initial release                                     |
// +--------------------------------------------------------------------+
module tb_mux_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] in0 = 8'h00;
  logic [7:0] in1 = 8'h00;
  int         n_checks = 0;
  int         n_fail   = 0;

  always #5 clk = ~clk;

  mux_scan_ctrl_if bus0 ();
  mux_scan_ctrl_if bus1 ();

  // Behavioural 8:1 muxes, combinational on the DUT select
  assign bus0.mux_out = in0[bus0.sel];
  assign bus1.mux_out = in1[bus1.sel];

  mux_scan_ctrl #(.SETTLE(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  mux_scan_ctrl #(.SETTLE(2)) dut2 (.clk(clk), .rst(rst), .bus(bus1));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus0.start = 1'b0; bus0.cont = 1'b0;
    bus1.start = 1'b0; bus1.cont = 1'b0;
    tick(); tick();
    n_checks++;
    if (bus0.sel !== 3'd0 || bus0.data !== 8'h00 || bus0.busy !== 1'b0 || bus0.done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset0: sel=%0d data=%h busy=%b done=%b, required 0/00/0/0",
               bus0.sel, bus0.data, bus0.busy, bus0.done);
    end
    n_checks++;
    if (bus1.sel !== 3'd0 || bus1.data !== 8'h00 || bus1.busy !== 1'b0 || bus1.done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset2: sel=%0d data=%h busy=%b done=%b, required 0/00/0/0",
               bus1.sel, bus1.data, bus1.busy, bus1.done);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single_settle0();
    in0 = 8'hA5;
    bus0.start = 1'b1;
    tick();
    bus0.start = 1'b0;
    n_checks++;
    if (bus0.busy !== 1'b1 || bus0.sel !== 3'd0) begin
      n_fail++;
      $display("FAIL s0_start: busy=%b sel=%0d, required 1/0", bus0.busy, bus0.sel);
    end
    for (int k = 1; k <= 8; k++) begin
      tick();
      n_checks++;
      if (bus0.sel !== ((k < 8) ? 3'(k) : 3'd7) || bus0.done !== (k == 8)) begin
        n_fail++;
        $display("FAIL s0_step%0d: sel=%0d done=%b, required %0d/%b",
                 k, bus0.sel, bus0.done, (k < 8) ? k : 7, (k == 8));
      end
    end
    n_checks++;
    if (bus0.data !== 8'hA5) begin
      n_fail++;
      $display("FAIL s0_data: data=%h, required a5", bus0.data);
    end
    tick();
    n_checks++;
    if (bus0.done !== 1'b0 || bus0.busy !== 1'b0 || bus0.sel !== 3'd0 || bus0.data !== 8'hA5) begin
      n_fail++;
      $display("FAIL s0_after: done=%b busy=%b sel=%0d data=%h, required 0/0/0/a5",
               bus0.done, bus0.busy, bus0.sel, bus0.data);
    end
  endtask

  task automatic test_settle2();
    in1 = 8'h3C;
    bus1.start = 1'b1;
    tick();
    bus1.start = 1'b0;
    for (int n = 1; n <= 24; n++) begin
      tick();
      n_checks++;
      if (bus1.sel !== ((n < 24) ? 3'(n / 3) : 3'd7) || bus1.done !== (n == 24)) begin
        n_fail++;
        $display("FAIL s2_edge%0d: sel=%0d done=%b, required %0d/%b",
                 n, bus1.sel, bus1.done, (n < 24) ? n / 3 : 7, (n == 24));
      end
    end
    n_checks++;
    if (bus1.data !== 8'h3C) begin
      n_fail++;
      $display("FAIL s2_data: data=%h, required 3c", bus1.data);
    end
    tick();
    n_checks++;
    if (bus1.busy !== 1'b0 || bus1.done !== 1'b0) begin
      n_fail++;
      $display("FAIL s2_idle: busy=%b done=%b, required 0/0", bus1.busy, bus1.done);
    end
  endtask

  task automatic test_continuous();
    logic [7:0] exp_data;
    in0 = 8'hFF;
    bus0.cont  = 1'b1;
    bus0.start = 1'b1;
    tick();
    bus0.start = 1'b0;
    exp_data = 8'hA5;
    for (int n = 1; n <= 27; n++) begin
      tick();
      // channels 0..5 of scan 2 are taken at E10..E15, 6..7 after the change
      if (n == 15) in0 = 8'h0F;
      if (n == 20) bus0.cont = 1'b0;
      if (n == 8)  exp_data = 8'hFF;
      if (n == 17) exp_data = 8'h3F;
      if (n == 26) exp_data = 8'h0F;
      n_checks++;
      if (bus0.done !== (n == 8 || n == 17 || n == 26) || bus0.data !== exp_data) begin
        n_fail++;
        $display("FAIL cont_edge%0d: done=%b data=%h, required %b/%h",
                 n, bus0.done, bus0.data, (n == 8 || n == 17 || n == 26), exp_data);
      end
    end
    n_checks++;
    if (bus0.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL cont_stop: busy=%b, required 0", bus0.busy);
    end
  endtask

  task automatic test_back_to_back();
    in0 = 8'h5A;
    bus0.start = 1'b1;
    tick();
    bus0.start = 1'b0;
    for (int n = 1; n <= 12; n++) begin
      tick();
      if (n == 3) bus0.start = 1'b1;
      if (n == 6) bus0.start = 1'b0;
      n_checks++;
      if (bus0.done !== (n == 8) || bus0.busy !== (n <= 8)) begin
        n_fail++;
        $display("FAIL b2b_edge%0d: done=%b busy=%b, required %b/%b",
                 n, bus0.done, bus0.busy, (n == 8), (n <= 8));
      end
    end
    n_checks++;
    if (bus0.data !== 8'h5A) begin
      n_fail++;
      $display("FAIL b2b_data: data=%h, required 5a", bus0.data);
    end
  endtask

  task automatic test_reset_midscan();
    logic seen_done;
    in0 = 8'hC3;
    bus0.start = 1'b1;
    tick();
    bus0.start = 1'b0;
    for (int n = 1; n <= 4; n++) tick();
    n_checks++;
    if (bus0.sel !== 3'd4) begin
      n_fail++;
      $display("FAIL rst_mid_sel: sel=%0d, required 4", bus0.sel);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++;
    if (bus0.sel !== 3'd0 || bus0.data !== 8'h00 || bus0.busy !== 1'b0 || bus0.done !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid: sel=%0d data=%h busy=%b done=%b, required 0/00/0/0",
               bus0.sel, bus0.data, bus0.busy, bus0.done);
    end
    seen_done = 1'b0;
    for (int n = 0; n < 10; n++) begin
      tick();
      if (bus0.done !== 1'b0 || bus0.busy !== 1'b0) seen_done = 1'b1;
    end
    n_checks++;
    if (seen_done !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_quiet: activity=%b, required 0", seen_done);
    end
  endtask

  task automatic test_rst_and_start();
    rst = 1'b1;
    bus0.start = 1'b1;
    tick();
    n_checks++;
    if (bus0.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_start: busy=%b, required 0", bus0.busy);
    end
    rst = 1'b0;
    bus0.start = 1'b0;
    bus0.cont  = 1'b1;
    tick();
    n_checks++;
    if (bus0.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL cont_only: busy=%b, required 0", bus0.busy);
    end
    bus0.cont = 1'b0;
  endtask

  initial begin
    bus0.start = 1'b0; bus0.cont = 1'b0;
    bus1.start = 1'b0; bus1.cont = 1'b0;
    test_reset();
    test_single_settle0();
    test_settle2();
    test_continuous();
    test_back_to_back();
    test_reset_midscan();
    test_rst_and_start();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_mux_scan_ctrl
`default_nettype wire
